// File: rtl/rr_arb32_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_arb32_ctrl
//  Description : 32-way round-robin arbiter and grant sequencer. One owner at
//                a time holds a registered one-hot grant until it signals
//                done, drops its request, or reaches the hold-time limit.
//                Every release is followed by one dead (GAP) cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb32_ctrl #(
    parameter int N        = 32,
    parameter int IDXW     = 5,
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout,
    output logic [IDXW-1:0] ptr_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] c_hold_limit = CNTW'(MAX_HOLD);
    localparam logic [N-1:0]    c_one        = {{(N-1){1'b0}}, 1'b1};

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic [IDXW-1:0] r_idx, w_idx_nxt;
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_timeout, w_timeout_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic [IDXW-1:0] w_win;
    logic            w_any;
    logic            w_release;

    assign w_any = |req;

    // Winner search: the index arithmetic wraps at IDXW bits, and the
    // descending loop lets the hit closest to the pointer win.
    always_comb begin
        w_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[r_ptr + IDXW'(i)]) begin
                w_win = r_ptr + IDXW'(i);
            end
        end
    end

    // The owner is released by done, by dropping its request, or at the limit.
    assign w_release = done || !req[r_idx] || (r_cnt == c_hold_limit);

    // Next-state and next-output logic for the arbitration sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_valid_nxt   = r_valid;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = c_one << w_win;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = CNTW'(1);
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // Only the hold limit (with done low and request still up) flags a timeout.
                    w_timeout_nxt = !done && req[r_idx];
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = '0;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = r_idx + IDXW'(1);
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;
    assign ptr_o     = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb32_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb32_ctrl
//  Description : Self-checking bench for rr_arb32_ctrl: vector table, directed
//                rotation / reset / fairness sequences, and random traffic
//                against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arb32_ctrl;

    localparam int N        = 32;
    localparam int IDXW     = 5;
    localparam int MAX_HOLD = 4;
    localparam int CNTW     = 8;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        done = 1'b0;
    logic [31:0] req  = 32'd0;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic [4:0]  ptr_o;
    logic        gnt_valid;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: current owner (-1 = none), pointer, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    typedef struct {
        bit          rst;
        logic [31:0] req;
        bit          done;
        bit          v;
        logic [4:0]  idx;
        bit          to;
        logic [4:0]  ptr;
    } vec_t;

    vec_t tbl [24];
    int   gcount [32];

    rr_arb32_ctrl #(
        .N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
        .timeout(timeout), .ptr_o(ptr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge of the reference model, using the inputs present at the edge.
    task automatic model_edge();
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_gap = 1'b0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_hold == MAX_HOLD) begin
                m_to    = !done && req[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_hold  = 0;
                m_gap   = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (req != 32'd0) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    break;
                end
            end
            m_hold = 1;
        end
    endtask

    // Advance one cycle and compare every output with the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        check("ptr_o", 32'(ptr_o), 32'(m_ptr));
        if (m_owner >= 0) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic wait_grant(output int idx);
        int k = 0;
        while (!gnt_valid && k < 20) begin
            step();
            k++;
        end
        check("grant_wait_bound", 32'(gnt_valid), 32'd1);
        idx = int'(gnt_idx);
    endtask

    task automatic release_now();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        int   gi;
        int   exp_order [3];
        int   exp_ptr   [3];
        logic [31:0] r;

        // rst, req, done  ->  valid, idx, timeout, ptr
        tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0};
        tbl[1]  = '{1'b0, 32'h08, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 32'h08, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0};
        tbl[3]  = '{1'b0, 32'h08, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0};
        tbl[4]  = '{1'b0, 32'h08, 1'b1, 1'b0, 5'd0, 1'b0, 5'd4};
        tbl[5]  = '{1'b0, 32'h08, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4};
        tbl[6]  = '{1'b0, 32'h08, 1'b0, 1'b1, 5'd3, 1'b0, 5'd4};
        tbl[7]  = '{1'b0, 32'h08, 1'b1, 1'b0, 5'd0, 1'b0, 5'd4};
        tbl[8]  = '{1'b0, 32'h00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4};
        tbl[9]  = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd4};
        tbl[10] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd4};
        tbl[11] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd4};
        tbl[12] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd4};
        tbl[13] = '{1'b0, 32'h80, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8};
        tbl[14] = '{1'b0, 32'h80, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8};
        tbl[15] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd8};
        tbl[16] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd8};
        tbl[17] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd8};
        tbl[18] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd8};
        tbl[19] = '{1'b0, 32'h80, 1'b1, 1'b0, 5'd0, 1'b0, 5'd8};
        tbl[20] = '{1'b0, 32'h80, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8};
        tbl[21] = '{1'b0, 32'h80, 1'b0, 1'b1, 5'd7, 1'b0, 5'd8};
        tbl[22] = '{1'b0, 32'h00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8};
        tbl[23] = '{1'b0, 32'h00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8};

        // Single requester, timeout, done-at-limit and owner-drop vectors.
        for (int i = 0; i < 24; i++) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            check($sformatf("tbl%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
            check($sformatf("tbl%0d_ptr", i), 32'(ptr_o), 32'(tbl[i].ptr));
            if (tbl[i].v) check($sformatf("tbl%0d_idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
        end
        rst = 1'b0; done = 1'b0;

        // Rotation across the wrap: park the pointer at 30, then serve {31,0,5}.
        req = 32'd1 << 29;
        wait_grant(gi);
        check("rot_pre_idx", 32'(gi), 32'd29);
        release_now();
        check("rot_pre_ptr", 32'(ptr_o), 32'd30);
        req = (32'd1 << 31) | 32'd1 | (32'd1 << 5);
        exp_order[0] = 31; exp_order[1] = 0; exp_order[2] = 5;
        exp_ptr[0]   = 0;  exp_ptr[1]   = 1; exp_ptr[2]   = 6;
        for (int i = 0; i < 3; i++) begin
            wait_grant(gi);
            check($sformatf("rot%0d_idx", i), 32'(gi), 32'(exp_order[i]));
            release_now();
            check($sformatf("rot%0d_ptr", i), 32'(ptr_o), 32'(exp_ptr[i]));
        end

        // Reset in the middle of a grant.
        req = 32'd1 << 12;
        wait_grant(gi);
        check("rstmid_idx", 32'(gi), 32'd12);
        rst = 1'b1;
        req = 32'hFFFF_FFFF;
        step();
        rst = 1'b0;
        check("rstmid_valid", 32'(gnt_valid), 32'd0);
        check("rstmid_gnt", gnt, 32'd0);
        check("rstmid_ptr", 32'(ptr_o), 32'd0);
        step();
        check("rstmid_first", 32'(gnt_idx), 32'd0);

        // Fairness sweep: 64 grants with all requesters active.
        for (int i = 0; i < 32; i++) gcount[i] = 0;
        for (int g = 0; g < 64; g++) begin
            wait_grant(gi);
            check($sformatf("fair%0d_idx", g), 32'(gi), 32'(g % 32));
            if (gi >= 0 && gi < 32) gcount[gi]++;
            release_now();
        end
        for (int i = 0; i < 32; i++) check($sformatf("fair_count%0d", i), 32'(gcount[i]), 32'd2);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r = 32'hFFFF_FFFF;
                    1:       r = 32'd1 << $urandom_range(0, 31);
                    2:       r = $urandom;
                    default: r = $urandom & $urandom & $urandom;
                endcase
                req = r;
            end
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; done = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arb32_ctrl.md
Name: rr_arb32_ctrl

Overview:
- Round-robin arbiter and grant sequencer that shares one 32-way select resource among 32 requesters.
- The winning index drives the team's 5-to-32 one-hot decode. The block publishes the index and a registered one-hot grant.
- Each grant lasts until the owner signals done, drops its request, or hits a hold-time limit.
- Sits between requester clients and the shared bus/port mux.

Parameters:
- N, 32, number of requesters; fixed at 32 so the index fits the 5-bit decode.
- IDXW, 5, index width; must equal log2(N).
- MAX_HOLD, 16, maximum grant length in cycles; legal range 1..255.
- CNTW, 8, hold-counter width; must satisfy 2^CNTW > MAX_HOLD.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- req  in  32  Request vector; bit i high means requester i wants the resource.
- done  in  1  Current owner releases the resource; sampled only in GRANT.
- gnt  out  32  Registered one-hot grant; all zero when no grant is active.
- gnt_idx  out  5  Binary index of the current owner; valid only when gnt_valid=1.
- gnt_valid  out  1  High while a grant is active (equals |gnt).
- timeout  out  1  One-cycle pulse when a grant is revoked by the hold limit.
- ptr_o  out  5  Current round-robin priority pointer (debug/observability).

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr_o=0, hold counter=0.
  - Reset overrides everything, including mid-grant: the grant drops the cycle after the rst edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select winner w = first set bit of req scanning ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32 wrap).
  - Next edge: gnt_idx=w, gnt = one-hot decode of w, gnt_valid=1, counter=1, state=GRANT.
  - Latency: req high at edge t gives gnt at edge t+1. The request must be high at the sampling edge.
- GRANT, release conditions, in priority order:
  1. done=1 -> release, timeout stays 0.
  2. req[gnt_idx]=0 -> release, timeout stays 0.
  3. counter==MAX_HOLD -> release, timeout=1 for one cycle.
  - Otherwise counter increments; gnt and gnt_idx hold stable.
  - Simultaneous done and limit: treated as done, no timeout pulse.
- Release (all causes):
  - Next edge: gnt=0, gnt_valid=0, ptr = gnt_idx+1 mod 32 (31 wraps to 0), counter=0, state=GAP.
  - gnt_idx retains its last value but is don't-care while gnt_valid=0.
- GAP: exactly one dead cycle with no grant (mux turnaround); then IDLE unconditionally.
  - Minimum spacing between grants is 2 cycles: release edge, GAP, then arbitration in IDLE.
- ptr changes only on release; it is never moved by arbitration alone.
- Requests rising or falling on non-owner bits during GRANT have no effect.
- timeout is registered, asserted only in the cycle following the revoke edge, and 0 otherwise.
- Fairness: with req all ones, grants visit indices 0..31 in order, then wrap.
- gnt must always be one-hot or zero. Zero is never paired with gnt_valid=1.

Test Plan:
- Single requester: rst, then req=32'h0000_0008 held, done pulsed 3 cycles after grant -> gnt=32'h8 and gnt_idx=3 one cycle after req; release; GAP; regrant of 3 with ptr_o=4.
- Rotation and wrap: ptr forced to 30 via prior grant of 29; req bits {31,0,5} set with done pulsed each grant -> grant order 31, 0, 5; ptr_o sequence 0, 1, 6.
- Timeout: MAX_HOLD=4, req[7] held, done=0 -> gnt_idx=7 for exactly 4 cycles; timeout=1 for one cycle; gnt=0; next grant goes to another requester if pending, else back to 7.
- Simultaneous events: done=1 in the same cycle the counter hits MAX_HOLD -> release, timeout stays 0. Owner drops req while done=0 -> release, no timeout.
- Reset mid-grant: gnt_idx=12 active, rst=1 for one edge -> next cycle gnt=0, gnt_valid=0, ptr_o=0, state IDLE. With req=all ones after reset, the first grant goes to index 0.
- Fairness sweep: req=32'hFFFF_FFFF, done pulsed every grant for 64 grants -> each index granted exactly twice, in order 0..31, 0..31. gnt one-hot checked every cycle.
